// File: rtl/sig_pio_responder_if.sv
// sig_pio_responder_if: PIO words and core operand/result buses of the sigmoid mailbox responder
interface sig_pio_responder_if;
  logic [31:0] data_in;
  logic [7:0]  ctrl_in;
  logic [31:0] result_out;
  logic [15:0] status_out;
  logic [31:0] sig_x_out;
  logic [31:0] sig_y_in;
  logic [31:0] isig_x_out;
  logic [31:0] isig_y_in;
  modport slave (
    input  data_in, ctrl_in, sig_y_in, isig_y_in,
    output result_out, status_out, sig_x_out, isig_x_out
  );
  modport master (
    output data_in, ctrl_in, sig_y_in, isig_y_in,
    input  result_out, status_out, sig_x_out, isig_x_out
  );
endinterface

// File: rtl/sig_pio_responder.sv
// sig_pio_responder: toggle-handshake PIO bridge to sigmoid/inverse-sigmoid cores; SIG_RESP_TXN_COUNT_EN adds a done counter in status[15:8]
module sig_pio_responder #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] NAN_RESULT    = 32'h7FC00000
) (
  input logic clk_clk,
  input logic reset_reset_n,
  sig_pio_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;
  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);
  state_t state, state_nx;
  logic [7:0] cnt, txn_cnt;
  logic op_r, err_r, ack_r, busy_r, err_q;
  logic [31:0] y_r, result_r, sig_x_r, isig_x_r;
  logic pending, nan_in, unused_ctrl;
  assign pending = bus.ctrl_in[0] != ack_r;
  assign nan_in = bus.data_in[30:23] == 8'hFF;
  assign unused_ctrl = &{1'b0, bus.ctrl_in[7:2]};
  assign bus.result_out = result_r;
  assign bus.status_out = {txn_cnt, 5'b0, err_q, busy_r, ack_r};
  assign bus.sig_x_out = sig_x_r;
  assign bus.isig_x_out = isig_x_r;
  always_ff @(posedge clk_clk)
    state <= !reset_reset_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE    ? (pending ? (nan_in ? DONE : SETTLE) : IDLE) :
               state == SETTLE  ? (cnt == 8'd0 ? CAPTURE : SETTLE) :
               state == CAPTURE ? DONE : IDLE;
  end
  // NaN/inf operands skip the cores entirely, so their x outputs stay at 0
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cnt <= '0;
      op_r <= 1'b0;
      err_r <= 1'b0;
      ack_r <= 1'b0;
      busy_r <= 1'b0;
      err_q <= 1'b0;
      y_r <= '0;
      result_r <= '0;
      sig_x_r <= '0;
      isig_x_r <= '0;
    end else begin
      if (state == IDLE && pending) begin
        op_r <= bus.ctrl_in[1];
        err_r <= nan_in;
        busy_r <= 1'b1;
        cnt <= CNT_INIT;
        if (!nan_in) begin
          sig_x_r <= bus.ctrl_in[1] ? '0 : bus.data_in;
          isig_x_r <= bus.ctrl_in[1] ? bus.data_in : '0;
        end
      end
      if (state == SETTLE) cnt <= cnt - 8'd1;
      if (state == CAPTURE) y_r <= op_r ? bus.isig_y_in : bus.sig_y_in;
      if (state == DONE) begin
        result_r <= err_r ? NAN_RESULT : y_r;
        err_q <= err_r;
        ack_r <= ~ack_r;
        busy_r <= 1'b0;
        sig_x_r <= '0;
        isig_x_r <= '0;
      end
    end
  end
`ifdef SIG_RESP_TXN_COUNT_EN
  always_ff @(posedge clk_clk)
    txn_cnt <= !reset_reset_n ? 8'd0 : state == DONE ? txn_cnt + 8'd1 : txn_cnt;
`else
  assign txn_cnt = '0;
`endif
endmodule

// File: tb/tb_sig_pio_responder.sv
// tb_sig_pio_responder: directed stimulus with a queue scoreboard checked by an ack-toggle monitor
module tb_sig_pio_responder;
  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic req = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] res;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb[$];
  sig_pio_responder_if bus ();
  sig_pio_responder dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus(bus)
  );
  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // ack at sampling edge (cyc+1) plus dly edges
  task automatic issue(input logic op, input logic [31:0] d, input logic [31:0] res, input logic err, input int dly);
    exp_t e;
    req = ~req;
    bus.ctrl_in = {6'b0, op, req};
    bus.data_in = d;
    e.res = res;
    e.err = err;
    e.at = cyc + 1 + dly;
    sb.push_back(e);
  endtask
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clk_clk);
      if (i == 1) bus.data_in = 32'hFFFF_FFFF;
    end
    chk("timeout_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk_clk);
  endtask
  task automatic watch_x(input int n, input logic [31:0] sx, input logic [31:0] ix);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_clk);
      chk("sig_x", bus.sig_x_out, sx);
      chk("isig_x", bus.isig_x_out, ix);
    end
  endtask
  initial begin
    logic prev_ack;
    int done_cnt;
    logic [7:0] exp_cnt;
    exp_t e;
    prev_ack = 1'b0;
    done_cnt = 0;
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        prev_ack = 1'b0;
        done_cnt = 0;
        continue;
      end
      if (bus.status_out[0] != prev_ack) begin
        prev_ack = bus.status_out[0];
        done_cnt++;
`ifdef SIG_RESP_TXN_COUNT_EN
        exp_cnt = 8'(done_cnt);
`else
        exp_cnt = 8'd0;
`endif
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("result", bus.result_out, e.res);
          chk("error", 32'(bus.status_out[2]), 32'(e.err));
          chk("busy_at_ack", 32'(bus.status_out[1]), 32'd0);
          chk("latency", 32'(cyc), 32'(e.at));
          chk("zero_bits", 32'(bus.status_out[7:3]), 32'd0);
          chk("txn_cnt", 32'(bus.status_out[15:8]), 32'(exp_cnt));
        end
      end
    end
  end
  initial begin
    bus.data_in = '0;
    bus.ctrl_in = '0;
    bus.sig_y_in = '0;
    bus.isig_y_in = '0;
    repeat (3) @(negedge clk_clk);
    chk("rst_result", bus.result_out, 32'd0);
    chk("rst_status", 32'(bus.status_out), 32'd0);
    chk("rst_sig_x", bus.sig_x_out, 32'd0);
    chk("rst_isig_x", bus.isig_x_out, 32'd0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    bus.sig_y_in = 32'h3F000000;
    bus.isig_y_in = 32'hDEADBEEF;
    issue(1'b0, 32'h00000000, 32'h3F000000, 1'b0, 6);
    watch_x(5, 32'h0, 32'h0);
    wait_done(20);
    bus.sig_y_in = 32'h3F800000;
    bus.isig_y_in = 32'h00000000;
    issue(1'b1, 32'h3F000000, 32'h00000000, 1'b0, 6);
    @(negedge clk_clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_clk);
      chk("settle_isig_x", bus.isig_x_out, 32'h3F000000);
      chk("settle_sig_x", bus.sig_x_out, 32'h0);
      chk("settle_busy", 32'(bus.status_out[1]), 32'd1);
    end
    wait_done(20);
    chk("x_idle_sig", bus.sig_x_out, 32'h0);
    chk("x_idle_isig", bus.isig_x_out, 32'h0);
    issue(1'b0, 32'h7F800000, 32'h7FC00000, 1'b1, 1);
    watch_x(3, 32'h0, 32'h0);
    wait_done(20);
    bus.sig_y_in = 32'h3F3B26A8;
    issue(1'b0, 32'h3F800000, 32'h3F3B26A8, 1'b0, 6);
    wait_done(20);
    bus.sig_y_in = 32'h3F612A7E;
    bus.isig_y_in = 32'h3F8C9F54;
    issue(1'b0, 32'h40000000, 32'h3F612A7E, 1'b0, 6);
    repeat (2) @(negedge clk_clk);
    issue(1'b1, 32'h3F400000, 32'h3F8C9F54, 1'b0, 11);
    for (int i = 0; i < 20 && sb.size() > 1; i++) @(negedge clk_clk);
    repeat (2) @(negedge clk_clk);
    chk("overlap_isig_x", bus.isig_x_out, 32'h3F400000);
    chk("overlap_sig_x", bus.sig_x_out, 32'h0);
    wait_done(20);
    issue(1'b0, 32'h3F800000, 32'h12345678, 1'b0, 6);
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b0;
    req = 1'b0;
    bus.ctrl_in = '0;
    sb.delete();
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_clk);
      chk("post_rst_result", bus.result_out, 32'd0);
      chk("post_rst_status", 32'(bus.status_out), 32'd0);
      chk("post_rst_x", bus.sig_x_out | bus.isig_x_out, 32'd0);
    end
    bus.isig_y_in = 32'h40400000;
    issue(1'b1, 32'h3E800000, 32'h40400000, 1'b0, 6);
    wait_done(20);
    issue(1'b1, 32'h7FC00001, 32'h7FC00000, 1'b1, 1);
    wait_done(20);
    for (int i = 0; i < 260; i++) begin
      issue(1'(i), 32'hFF800000, 32'h7FC00000, 1'b1, 1);
      wait_done(10);
    end
    chk("final_busy", 32'(bus.status_out[1]), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sig_pio_responder.md
Name: sig_pio_responder

Overview:
Hardware-side responder for the Nios software mailbox that drives the sigmoid and inverse-sigmoid cores through SoC PIO words. Software writes an IEEE-754 single operand and toggles a request bit. The block latches the operand and launches it into the selected core. It waits a fixed settle time across the core's multicycle combinational path, captures the result, and toggles an acknowledge bit. It sits between the SoC PIO exports and the spu/ispu instances, replacing their direct PIO wiring.

Parameters:
SETTLE_CYCLES, 4, cycles the selected core's x input is held stable before y is captured; legal range 1..255.
NAN_RESULT, 32'h7FC00000, result word returned for inputs with exponent field 8'hFF.

Ports:
clk_clk  in  1  system clock (same domain as the SoC PIOs)
reset_reset_n  in  1  reset; synchronous, active-low
data_in  in  32  operand x (float) from the software-written PIO
ctrl_in  in  8  from the software-written PIO; bit0 req toggle, bit1 op (0 sigmoid, 1 inverse sigmoid), bits7:2 ignored
result_out  out  32  y (float) to the software-read PIO
status_out  out  16  bit0 ack toggle, bit1 busy, bit2 error, bits7:3 zero, bits15:8 transaction count (see Optional Feature)
sig_x_out  out  32  operand to sigmoid core
sig_y_in  in  32  sigmoid core result
isig_x_out  out  32  operand to inverse-sigmoid core
isig_y_in  in  32  inverse-sigmoid core result

Behaviour:
- Reset (reset_reset_n low at a rising edge):
  - state IDLE; result_out, status_out, sig_x_out and isig_x_out all 0.
  - Reset mid-operation aborts the transaction; no ack is issued.
- Pending request: ctrl_in[0] != status_out[0]. This is toggle handshake semantics. At most one request is outstanding; software toggles again only after observing ack == req.
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE, pending sampled at edge t:
  - Latch data_in into x_r and ctrl_in[1] into op_r; busy <= 1.
  - If data_in[30:23] == 8'hFF: next state DONE with err_r = 1; cores are not driven.
  - Otherwise: next state SETTLE, cnt <= SETTLE_CYCLES-1, err_r = 0.
- SETTLE:
  - The selected core's x output is driven with x_r. The unselected core's x output is held at 0.
  - x outputs are registered and stable throughout SETTLE and CAPTURE.
  - cnt decrements each cycle; at cnt == 0, go to CAPTURE.
- CAPTURE:
  - y_r <= sig_y_in if op_r == 0, else isig_y_in. Go to DONE.
- DONE (single edge), updated together in the same edge:
  - result_out <= NAN_RESULT if err_r, else y_r.
  - status[2] <= err_r; status[0] <= ~status[0]; busy <= 0.
  - Both x outputs return to 0; next state IDLE.
- Latency from sampling edge t:
  - Normal path: ack toggles at edge t+SETTLE_CYCLES+2 (t+6 at default).
  - Error path: ack toggles at t+1.
- result_out and status[2] hold their values until the next DONE. status[2] reflects only the most recent transaction.
- data_in/ctrl_in changes after edge t are ignored for the running transaction.
- A req toggle while busy remains pending and is sampled in the first IDLE cycle after DONE. There is no idle bubble requirement beyond that single IDLE cycle.
- If ctrl_in[0] = 1 when reset releases, a request is pending immediately (ack resets to 0). Software clears the req bit before releasing reset or accepts one spurious transaction.

Optional Feature:
Macro SIG_RESP_TXN_COUNT_EN.
- Defined: status_out[15:8] is an 8-bit counter, reset to 0. It increments in every DONE (error transactions included) and wraps 255 -> 0.
- Undefined: status_out[15:8] is tied to 0 and no counter register exists.

Test Plan:
- Op 0, data_in 32'h00000000, core stub sig_y_in = 32'h3F000000, req 0->1 sampled at edge t -> sig_x_out = 0 during SETTLE; at t+6: result_out 32'h3F000000, status[0] = 1, busy 0, error 0; isig_x_out stays 0.
- Op 1, data_in 32'h3F000000, isig_y_in = 32'h00000000, req 1->0 -> isig_x_out = 32'h3F000000 for 4 cycles; at t+6: result_out 0, status[0] = 0.
- data_in 32'h7F800000 (inf), op 0 -> at t+1: result_out 32'h7FC00000, error 1, ack toggled; sig_x_out and isig_x_out never leave 0. A following normal request clears error.
- Second req toggle during SETTLE of the first -> first completes at t+6; second is sampled at t+7 and acks at t+13 with its own operand.
- reset_reset_n low during SETTLE, then high with ctrl_in[0] = 0 -> all outputs 0, no ack, state IDLE. The next request completes normally.
- With SIG_RESP_TXN_COUNT_EN: 256 back-to-back transactions -> status[15:8] reads 255, then 0. Without the macro -> status[15:8] = 0 throughout.
